// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin front end sharing one fixed-latency memory port among NUM_CH requesters.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module mem_req_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_hit,
  output logic                     read_en,
  output logic                     write_en,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        write_data,
  input  logic [DATA_W-1:0]        read_data,
  input  logic                     hit,
  output logic [CNT_W-1:0]         access_count,
  output logic [CNT_W-1:0]         hit_count,
  output logic [ADDR_W-1:0]        dbg_address,
  output logic                     dbg_hit,
  output logic [DATA_W-1:0]        dbg_read_data
);

  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant_q;
  logic            we_q;
  logic [LW-1:0]   lat_cnt;

  logic            grant_found;
  logic [GW-1:0]   grant_idx;

  // Search starts just above the previous winner and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && (state == IDLE) && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= GW'(NUM_CH - 1);
      grant_q      <= '0;
      we_q         <= 1'b0;
      lat_cnt      <= '0;
      rsp_valid    <= '0;
      rsp_rdata    <= '0;
      rsp_hit      <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant_q    <= grant_idx;
            last_grant <= grant_idx;
            we_q       <= req_we[grant_idx];
            address    <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            write_data <= req_wdata[grant_idx*DATA_W +: DATA_W];
            read_en    <= ~req_we[grant_idx];
            write_en   <= req_we[grant_idx];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          read_en  <= 1'b0;
          write_en <= 1'b0;
          lat_cnt  <= LW'(MEM_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          // lat_cnt reaches zero in the MEM_LATENCY-th cycle after ISSUE.
          if (lat_cnt == '0) begin
            rsp_valid[grant_q] <= 1'b1;
            rsp_rdata          <= we_q ? '0 : read_data;
            rsp_hit            <= hit;
            if (access_count != '1) begin
              access_count <= access_count + 1'b1;
            end
            if (hit && (hit_count != '1)) begin
              hit_count <= hit_count + 1'b1;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_address   = address;
  assign dbg_hit       = rsp_hit;
  assign dbg_read_data = rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed stimulus against a transaction-level model of the arbiter.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_req_arbiter;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int L      = 2;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH-1:0]        req_we = '0;
  logic [NUM_CH*ADDR_W-1:0] req_addr = '0;
  logic [NUM_CH*DATA_W-1:0] req_wdata = '0;
  logic [NUM_CH-1:0]        req_ready, rsp_valid;
  logic [DATA_W-1:0]        rsp_rdata, write_data, read_data, dbg_read_data;
  logic                     rsp_hit, read_en, write_en, hit, dbg_hit;
  logic [ADDR_W-1:0]        address, dbg_address;
  logic [CNT_W-1:0]         access_count, hit_count;

  mem_req_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(L), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .read_en(read_en), .write_en(write_en), .address(address), .write_data(write_data),
    .read_data(read_data), .hit(hit),
    .access_count(access_count), .hit_count(hit_count),
    .dbg_address(dbg_address), .dbg_hit(dbg_hit), .dbg_read_data(dbg_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Memory stub: data and hit are valid only in the L-th cycle after the strobe.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  logic [L-1:0]      hist = '0;
  logic [DATA_W-1:0] lat_rd = '0;
  logic              lat_hit = 1'b0;

  always @(posedge clk) begin
    hist <= {hist[0], read_en | write_en};
    if (read_en | write_en) begin
      lat_rd  <= mem_val(address);
      lat_hit <= address[4];
    end
  end

  assign read_data = hist[L-1] ? lat_rd : 32'hBAD0BAD0;
  assign hit       = hist[L-1] ? lat_hit : ~lat_hit;

  // Transaction model: m_k counts cycles since acceptance (1 = issue, L+2 = response).
  logic              m_busy = 1'b0;
  int                m_k = 0, m_g = 0, m_last = NUM_CH - 1, m_pick;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;
  logic              m_hit = 1'b0;
  int                m_acc = 0, m_hitc = 0;

  function automatic int rr_pick(input logic [NUM_CH-1:0] v, input int last);
    for (int i = 1; i <= NUM_CH; i++) begin
      if (v[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_k <= 0; m_g <= 0; m_last <= NUM_CH - 1; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_hit <= 1'b0; m_acc <= 0; m_hitc <= 0;
    end else if (!m_busy) begin
      m_pick = rr_pick(req_valid, m_last);
      if (m_pick >= 0) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_g     <= m_pick;
        m_last  <= m_pick;
        m_we    <= req_we[m_pick];
        m_addr  <= req_addr[m_pick*ADDR_W +: ADDR_W];
        m_wdata <= req_wdata[m_pick*DATA_W +: DATA_W];
      end
    end else begin
      if (m_k == L + 1) begin
        m_rdata <= m_we ? '0 : mem_val(m_addr);
        m_hit   <= m_addr[4];
        if (m_acc < CMAX) m_acc <= m_acc + 1;
        if (m_addr[4] && (m_hitc < CMAX)) m_hitc <= m_hitc + 1;
      end
      if (m_k == L + 2) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  int                log_g[$];
  int                log_c[$];
  int                c_pick;
  logic [NUM_CH-1:0] e_ready, e_rsp;

  always @(negedge clk) begin
    #1;
    c_pick  = rr_pick(req_valid, m_last);
    e_ready = '0;
    if (reset && !m_busy && (c_pick >= 0)) e_ready[c_pick] = 1'b1;
    e_rsp = '0;
    if (m_busy && (m_k == L + 2)) e_rsp[m_g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("read_en", 64'(read_en), 64'(m_busy && (m_k == 1) && !m_we));
    chk("write_en", 64'(write_en), 64'(m_busy && (m_k == 1) && m_we));
    chk("address", 64'(address), 64'(m_addr));
    chk("write_data", 64'(write_data), 64'(m_wdata));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    chk("rsp_hit", 64'(rsp_hit), 64'(m_hit));
    chk("access_count", 64'(access_count), 64'(m_acc));
    chk("hit_count", 64'(hit_count), 64'(m_hitc));
    chk("dbg_mirrors", {dbg_address, dbg_read_data, 15'd0, dbg_hit},
        {m_addr, m_rdata, 15'd0, m_hit});
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ready[i]) begin
        log_g.push_back(i);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_req(input int ch, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_we[ch] = we;
    req_addr[ch*ADDR_W +: ADDR_W] = a;
    req_wdata[ch*DATA_W +: DATA_W] = d;
    req_valid[ch] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #2;
      if (req_ready[ch]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 64'(got), 64'd1);
    @(negedge clk);
    req_valid[ch] = 1'b0;
    #2;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (!m_busy) break;
      step();
    end
    chk("idle_timeout", 64'(m_busy), 64'd0);
  endtask

  task automatic wait_grants(input int target, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (log_g.size() >= target) break;
      step();
    end
    chk("grant_timeout", 64'(log_g.size() >= target), 64'd1);
  endtask

  initial begin
    int n0;
    int rspcnt;
    // Reset state, including gating of req_ready while reset is low.
    req_valid = 4'b0001;
    repeat (2) step();
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_counts", 64'({access_count, hit_count}), 64'd0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    step();

    // Read hit on ch0.
    do_req(0, 1'b0, 16'h0010, 32'h0);
    chk("t1_read_en_c1", 64'({read_en, write_en}), 64'b10);
    chk("t1_address", 64'(address), 64'h0010);
    step();
    chk("t1_read_en_c2", 64'(read_en), 64'd0);
    step();
    chk("t1_no_rsp_c3", 64'(rsp_valid), 64'd0);
    step();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
    chk("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("t1_counts", 64'({access_count, hit_count, 3'd0, rsp_hit}), 64'h111);
    step();

    // Write miss on ch1.
    do_req(1, 1'b1, 16'h0020, 32'h12345678);
    chk("t2_strobes", 64'({read_en, write_en}), 64'b01);
    chk("t2_write_data", 64'(write_data), 64'h12345678);
    repeat (3) step();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'b0010);
    chk("t2_rdata", 64'(rsp_rdata), 64'd0);
    chk("t2_hit", 64'(rsp_hit), 64'd0);
    chk("t2_counts", 64'({access_count, hit_count}), 64'h21);
    wait_idle();

    // ch0 and ch1 both requesting continuously.
    n0 = log_g.size();
    @(negedge clk);
    req_we = '0;
    req_addr[0*ADDR_W +: ADDR_W] = 16'h0100;
    req_addr[1*ADDR_W +: ADDR_W] = 16'h0101;
    req_valid = 4'b0011;
    wait_grants(n0 + 4, 60);
    @(negedge clk);
    req_valid = '0;
    if (log_g.size() >= n0 + 4) begin
      chk("t3_grant_order", 64'({log_g[n0][3:0], log_g[n0+1][3:0], log_g[n0+2][3:0],
                                 log_g[n0+3][3:0]}), 64'h0101);
      for (int i = 1; i < 4; i++) begin
        chk("t3_spacing", 64'(log_c[n0+i] - log_c[n0+i-1]), 64'(L + 3));
      end
    end
    wait_idle();

    // last_grant=2, then ch2 and ch3 contend.
    do_req(2, 1'b0, 16'h0200, 32'h0);
    wait_idle();
    n0 = log_g.size();
    @(negedge clk);
    req_addr[2*ADDR_W +: ADDR_W] = 16'h0202;
    req_addr[3*ADDR_W +: ADDR_W] = 16'h0303;
    req_valid = 4'b1100;
    wait_grants(n0 + 2, 30);
    @(negedge clk);
    req_valid = '0;
    if (log_g.size() >= n0 + 2) begin
      chk("t4_grant_order", 64'({log_g[n0][3:0], log_g[n0+1][3:0]}), 64'h32);
    end
    wait_idle();

    // Reset asserted while waiting on memory.
    do_req(0, 1'b0, 16'h0030, 32'h0);
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_strobes", 64'({req_ready, rsp_valid, read_en, write_en, rsp_hit, dbg_hit}), 64'd0);
    chk("t5_rst_addr_data", 64'({address, write_data}), 64'd0);
    chk("t5_rst_rdata_counts", 64'({rsp_rdata, access_count, hit_count, dbg_address}), 64'd0);
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    rspcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid != '0) rspcnt++;
    end
    chk("t5_no_rsp_after_reset", 64'(rspcnt), 64'd0);
    @(negedge clk);
    req_addr[0*ADDR_W +: ADDR_W] = 16'h0040;
    req_addr[1*ADDR_W +: ADDR_W] = 16'h0041;
    req_valid = 4'b0011;
    #2;
    chk("t5_first_grant", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_idle();
    chk("t5_counts", 64'({access_count, hit_count}), 64'h10);

    // 17 read hits saturate both 4-bit counters.
    n0 = log_g.size();
    @(negedge clk);
    req_addr[3*ADDR_W +: ADDR_W] = 16'h0F10;
    req_valid = 4'b1000;
    wait_grants(n0 + 17, 17 * (L + 3) + 20);
    @(negedge clk);
    req_valid = '0;
    wait_idle();
    step();
    chk("t6_access_sat", 64'(access_count), 64'd15);
    chk("t6_hit_sat", 64'(hit_count), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
